// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and data access.
// Data access has priority; fetch is guaranteed a slot after MAX_DATA_RUN data grants and hung transactions time out.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_data_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic        stallreq_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] BUSY_IF  = 2'd1;
    localparam logic [1:0] BUSY_MEM = 2'd2;

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [TW-1:0] TIMEOUT_LIM = TW'(TIMEOUT);
    localparam logic [RW-1:0] RUN_LIM     = RW'(MAX_DATA_RUN);

    logic [1:0]    state;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic [RW-1:0] run_cnt;
    logic          grant_mem;
    logic          finish;
    logic [31:0]   ret_data;

    always_comb begin
        grant_mem = mem_req_i && !(if_req_i && (run_cnt == RUN_LIM));
        tmo_next  = tmo_cnt + 1'b1;
        // A real ack on the timeout edge takes precedence over the abort
        finish    = bus_ack_i || (tmo_next == TIMEOUT_LIM);
        ret_data  = (bus_ack_i && !bus_we_o) ? bus_rdata_i : '0;
    end

    always_comb begin
        stallreq_o = !rst && ((if_req_i && !if_ack_o) || (mem_req_i && !mem_ack_o));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            run_cnt     <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            err_o     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        state       <= BUSY_MEM;
                        tmo_cnt     <= '0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= mem_we_i;
                        bus_sel_o   <= mem_sel_i;
                        bus_addr_o  <= mem_addr_i;
                        bus_wdata_o <= mem_wdata_i;
                        if (!if_req_i) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_LIM) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                    end else if (if_req_i) begin
                        state       <= BUSY_IF;
                        tmo_cnt     <= '0;
                        run_cnt     <= '0;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= 1'b0;
                        bus_sel_o   <= 4'b1111;
                        bus_addr_o  <= if_addr_i;
                        bus_wdata_o <= '0;
                    end
                end
                BUSY_IF, BUSY_MEM: begin
                    if (finish) begin
                        state     <= IDLE;
                        bus_req_o <= 1'b0;
                        err_o     <= !bus_ack_i;
                        if (state == BUSY_IF) begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= ret_data;
                        end else begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= ret_data;
                        end
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT      = 16;
    localparam int MAX_DATA_RUN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ack_i = 1'b0;
    logic        stallreq_o;

    int checks = 0;
    int failures = 0;

    mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .MAX_DATA_RUN(MAX_DATA_RUN)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: who holds the bus, since which cycle, and how many data grants in a row
    int          m_cyc = 0;
    int          m_owner = 0;       // 0 = nobody, 1 = fetch, 2 = data
    int          m_grant_at = 0;
    int          m_run = 0;
    logic        m_write = 1'b0;
    logic        e_bus_req = 1'b0, e_bus_we = 1'b0;
    logic [3:0]  e_bus_sel = '0;
    logic [31:0] e_bus_addr = '0, e_bus_wdata = '0;
    logic        e_if_ack = 1'b0, e_mem_ack = 1'b0, e_err = 1'b0;
    logic [31:0] e_if_data = '0, e_mem_rdata = '0;

    always @(posedge clk) begin
        logic        done;
        logic        timed_out;
        logic [31:0] d;
        m_cyc++;
        if (rst) begin
            m_owner = 0; m_run = 0; m_write = 1'b0;
            e_bus_req = 0; e_bus_we = 0; e_bus_sel = '0; e_bus_addr = '0; e_bus_wdata = '0;
            e_if_ack = 0; e_mem_ack = 0; e_err = 0; e_if_data = '0; e_mem_rdata = '0;
        end else begin
            e_if_ack = 0; e_mem_ack = 0; e_err = 0;
            if (m_owner != 0) begin
                done = bus_ack_i || (m_cyc - m_grant_at == TIMEOUT);
                timed_out = !bus_ack_i;
                if (done) begin
                    d = (timed_out || m_write) ? 32'h0 : bus_rdata_i;
                    e_err = timed_out;
                    if (m_owner == 1) begin e_if_ack = 1; e_if_data = d; end
                    else begin e_mem_ack = 1; e_mem_rdata = d; end
                    m_owner = 0;
                end
            end else if (mem_req_i && !(if_req_i && m_run >= MAX_DATA_RUN)) begin
                m_owner = 2; m_grant_at = m_cyc; m_write = mem_we_i;
                e_bus_we = mem_we_i; e_bus_sel = mem_sel_i;
                e_bus_addr = mem_addr_i; e_bus_wdata = mem_wdata_i;
                m_run = if_req_i ? ((m_run < MAX_DATA_RUN) ? m_run + 1 : MAX_DATA_RUN) : 0;
            end else if (if_req_i) begin
                m_owner = 1; m_grant_at = m_cyc; m_write = 1'b0;
                e_bus_we = 1'b0; e_bus_sel = 4'b1111;
                e_bus_addr = if_addr_i; e_bus_wdata = '0;
                m_run = 0;
            end
            e_bus_req = (m_owner != 0);
        end
    end

    always @(negedge clk) begin
        chk("bus_req", bus_req_o, e_bus_req);
        chk("bus_we", bus_we_o, e_bus_we);
        chk("bus_sel", bus_sel_o, e_bus_sel);
        chk("bus_addr", bus_addr_o, e_bus_addr);
        chk("bus_wdata", bus_wdata_o, e_bus_wdata);
        chk("if_ack", if_ack_o, e_if_ack);
        chk("if_data", if_data_o, e_if_data);
        chk("mem_ack", mem_ack_o, e_mem_ack);
        chk("mem_rdata", mem_rdata_o, e_mem_rdata);
        chk("err", err_o, e_err);
        chk("stallreq", stallreq_o,
            !rst && ((if_req_i && !e_if_ack) || (mem_req_i && !e_mem_ack)));
        chk("ack_overlap", if_ack_o & mem_ack_o, 1'b0);
    end

    initial begin
        int          cnt;
        logic        got;
        logic        prev_req;
        logic [5:0]  seq;
        int          nrec;
        int          hang;

        // Reset with a pending fetch: stall must stay low during reset
        rst = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h8;
        tick(); tick();
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_if_ack", if_ack_o, 1'b0);
        chk("rst_mem_ack", mem_ack_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_stall", stallreq_o, 1'b0);
        rst = 1'b0; if_req_i = 1'b0;
        tick();

        // Fetch read acknowledged after two busy cycles
        if_req_i = 1'b1; if_addr_i = 32'h0000_0008;
        tick();
        chk("f_bus_req", bus_req_o, 1'b1);
        chk("f_bus_addr", bus_addr_o, 32'h8);
        chk("f_bus_we", bus_we_o, 1'b0);
        chk("f_bus_sel", bus_sel_o, 4'hF);
        chk("f_stall", stallreq_o, 1'b1);
        tick();
        chk("f_bus_req2", bus_req_o, 1'b1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h3401_1100;
        tick();
        chk("f_ack", if_ack_o, 1'b1);
        chk("f_data", if_data_o, 32'h3401_1100);
        chk("f_req_drop", bus_req_o, 1'b0);
        chk("f_stall_ack", stallreq_o, 1'b0);
        if_req_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'h5555_5555;
        tick();
        chk("f_ack_once", if_ack_o, 1'b0);
        chk("f_data_hold", if_data_o, 32'h3401_1100);

        // Simultaneous requests: data first, fetch one cycle after the data ack
        if_req_i = 1'b1; if_addr_i = 32'h100;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h200;
        tick();
        chk("s_first_addr", bus_addr_o, 32'h200);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A5_0001;
        tick();
        chk("s_mem_ack", mem_ack_o, 1'b1);
        chk("s_if_noack", if_ack_o, 1'b0);
        chk("s_gap", bus_req_o, 1'b0);
        mem_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();
        chk("s_if_req", bus_req_o, 1'b1);
        chk("s_if_addr", bus_addr_o, 32'h100);
        bus_ack_i = 1'b1; bus_rdata_i = 32'hA5A5_0002;
        tick();
        chk("s_if_ack", if_ack_o, 1'b1);
        chk("s_if_data", if_data_o, 32'hA5A5_0002);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // Data write: read data returned must be zero
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h40; mem_wdata_i = 32'hDEAD_BEEF;
        tick();
        chk("w_we", bus_we_o, 1'b1);
        chk("w_sel", bus_sel_o, 4'b0011);
        chk("w_addr", bus_addr_o, 32'h40);
        chk("w_wdata", bus_wdata_o, 32'hDEAD_BEEF);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        tick();
        chk("w_ack", mem_ack_o, 1'b1);
        chk("w_rdata", mem_rdata_o, 32'h0);
        chk("w_err", err_o, 1'b0);
        mem_req_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // Starvation bound: grant order must be D D D D F D
        if_req_i = 1'b1; if_addr_i = 32'h1000;
        mem_req_i = 1'b1; mem_addr_i = 32'h2000; mem_sel_i = 4'hF;
        bus_ack_i = 1'b1;
        prev_req = 1'b0; seq = '0; nrec = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus_req_o && !prev_req && nrec < 6) begin
                seq = {seq[4:0], bus_addr_o == 32'h2000};
                nrec++;
            end
            prev_req = bus_req_o;
        end
        chk("starve_n", nrec, 6);
        chk("starve_seq", seq, 6'b111101);
        if_req_i = 1'b0; mem_req_i = 1'b0;
        tick(); tick();
        bus_ack_i = 1'b0;
        tick();

        // Timeout: no bus ack at all
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h300; bus_rdata_i = 32'hCAFE_F00D;
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (mem_ack_o) begin
                got = 1'b1;
                chk("t_err", err_o, 1'b1);
                chk("t_data", mem_rdata_o, 32'h0);
                chk("t_req_drop", bus_req_o, 1'b0);
            end else if (bus_req_o) begin
                cnt++;
            end
        end
        chk("t_seen", got, 1'b1);
        chk("t_len", cnt, TIMEOUT);
        mem_req_i = 1'b0;
        tick();
        chk("t_err_once", err_o, 1'b0);
        bus_ack_i = 1'b1;
        tick(); tick();
        chk("t_stray_ack", mem_ack_o, 1'b0);
        chk("t_stray_req", bus_req_o, 1'b0);
        bus_ack_i = 1'b0;
        tick();

        // Bus ack on the very edge the timeout would fire: completes normally
        mem_req_i = 1'b1; mem_addr_i = 32'h304; bus_rdata_i = 32'h600D_F00D;
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("tb_no_early", mem_ack_o, 1'b0);
        chk("tb_still_req", bus_req_o, 1'b1);
        bus_ack_i = 1'b1;
        tick();
        chk("tb_ack", mem_ack_o, 1'b1);
        chk("tb_err", err_o, 1'b0);
        chk("tb_data", mem_rdata_o, 32'h600D_F00D);
        mem_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // Reset in the middle of a data transaction, then a fresh fetch
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h500; mem_wdata_i = 32'h11;
        tick(); tick();
        rst = 1'b1; bus_ack_i = 1'b1;
        tick();
        chk("r_bus_req", bus_req_o, 1'b0);
        chk("r_bus_addr", bus_addr_o, 32'h0);
        chk("r_bus_wdata", bus_wdata_o, 32'h0);
        chk("r_mem_ack", mem_ack_o, 1'b0);
        chk("r_stall", stallreq_o, 1'b0);
        rst = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick();
        chk("r_late_ack", mem_ack_o, 1'b0);
        chk("r_idle", bus_req_o, 1'b0);
        bus_ack_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h8;
        tick();
        chk("r_f_req", bus_req_o, 1'b1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0A0B_0C0D;
        tick();
        chk("r_f_ack", if_ack_o, 1'b1);
        chk("r_f_data", if_data_o, 32'h0A0B_0C0D);
        if_req_i = 1'b0; bus_ack_i = 1'b0;
        tick();

        // Randomized traffic against the model
        hang = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst = ($urandom_range(299, 0) == 0);
            if (if_req_i) begin
                if (if_ack_o) begin
                    if ($urandom_range(1, 0) == 1) if_addr_i = $urandom & 32'hFFFF_FFFC;
                    else if_req_i = 1'b0;
                end else if ($urandom_range(79, 0) == 0) begin
                    if_req_i = 1'b0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                if_req_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (mem_req_i && !mem_ack_o) begin
                if ($urandom_range(79, 0) == 0) mem_req_i = 1'b0;
            end else if ($urandom_range(1, 0) == 0) begin
                mem_req_i = 1'b1; mem_we_i = $urandom_range(1, 0) == 1;
                mem_sel_i = 4'($urandom); mem_addr_i = $urandom; mem_wdata_i = $urandom;
            end else begin
                mem_req_i = 1'b0;
            end
            bus_rdata_i = $urandom;
            if (hang > 0) begin
                hang--;
                bus_ack_i = 1'b0;
            end else begin
                if ($urandom_range(99, 0) == 0) hang = $urandom_range(30, 10);
                bus_ack_i = ($urandom_range(2, 0) == 0);
            end
        end
        rst = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0; bus_ack_i = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
